// File: rtl/uart_receiver.sv
// 8N1 serial receiver: synchronizer, oversampling deframer and a show-ahead byte FIFO.
// Latency: a byte reaches the FIFO head one cycle after its stop-bit sample.
// Backpressure: none toward the line; a good byte arriving at a full FIFO is dropped and flagged.

// Generic show-ahead FIFO with occupancy count and wrapping power-of-2 pointers.
// Latency: a write is visible at rd_dat/empty on the cycle after the push edge.
// Backpressure: a write to a full FIFO is taken only when a pop happens in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign pop  = rd_rdy && !empty;
    assign push = wr_vld && (!full || pop);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
endmodule

module uart_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock_reg,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rxs;
    logic          stop_pt;
    logic          push_req;
    logic          pop;

    // Both stages reset high so reset release never looks like a start bit.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign stop_pt  = (state == S_STOP) && (cnt == CNT_LAST);
    assign push_req = stop_pt && rxs;
    assign pop      = rd_en && !empty;

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_pt && !rxs)    frame_err <= 1'b1;
            else if (err_clr)       frame_err <= 1'b0;
            // A pop in the stop-sample cycle frees the slot the push needs.
            if (push_req && full && !pop) overrun <= 1'b1;
            else if (err_clr)             overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rxs) state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (clock_reg),
        .arst_n   (reset),
        .wr_vld   (push_req),
        .wr_dat   (shreg),
        .rd_rdy   (rd_en),
        .rd_dat   (rd_data),
        .empty    (empty),
        .full     (full)
    );
endmodule

// File: tb/tb_uart_receiver.sv
// Randomized and directed 8N1 frames against a queue-based model of the receive FIFO and flags.
module tb_uart_receiver;
    localparam int DEPTH = 4;
    localparam int BIT_CLKS = 16;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic       clock_reg = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] mon_exp;

    uart_receiver #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock_reg (clock_reg),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clock_reg = ~clock_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop must return the oldest expected byte.
    always @(negedge clock_reg) begin
        if (reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_reg);
            #1;
        end
    endtask

    // Drives ncyc clocks of a frame; the model updates only for a complete frame.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pop_at_stop,
                              input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int b;
            b = c / BIT_CLKS;
            if (b == 0)      rx = 1'b0;
            else if (b <= 8) rx = d[b-1];
            else             rx = stop_ok;
            rd_en = pop_at_stop && (c == FRAME_CLKS - 6);
            tick(1);
        end
        rd_en = 1'b0;
        if (ncyc == FRAME_CLKS) begin
            if (!stop_ok)                 m_ferr = 1'b1;
            else if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                          m_ovr = 1'b1;
        end
    endtask

    task automatic read_n(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
        end
        tick(1);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_empty"}, empty, exp_q.size() == 0);
        check({tag, "_full"}, full, exp_q.size() == DEPTH);
        check({tag, "_overrun"}, overrun, m_ovr);
        check({tag, "_frame_err"}, frame_err, m_ferr);
        if (exp_q.size() != 0) check({tag, "_head"}, rd_data, exp_q[0]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the summary, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        int low_cnt;
        reset = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tick(3);
        check_reset_vals("reset");
        reset = 1'b1;
        tick(2);

        // Single byte
        send_frame(8'hA5, 1, 0, FRAME_CLKS);
        check("single_busy", busy, 0);
        check_state("single");
        read_n(1);
        check_state("single_read");

        // Glitch on the line
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) seen = 1;
            tick(1);
        end
        check("glitch_busy_pulse", seen, 1);
        check("glitch_busy_end", busy, 0);
        check_state("glitch");

        // Framing error with the line held low afterwards
        send_frame(8'h3C, 0, 0, FRAME_CLKS);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) low_cnt++;
            tick(1);
        end
        check("break_busy_held", low_cnt, 0);
        check_state("frame");
        rx = 1'b1;
        tick(5);
        check("break_released", busy, 0);
        send_frame(8'h55, 1, 0, FRAME_CLKS);
        check_state("after_break");
        read_n(1);
        clear_errs();
        check_state("err_clr");

        // Overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1, 0, FRAME_CLKS);
            check_state($sformatf("ovr%0d", i));
        end
        read_n(5);
        check_state("ovr_drain");
        clear_errs();

        // Push and pop in the stop-sample cycle of the fifth byte
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1, 0, FRAME_CLKS);
        send_frame(8'h15, 1, 1, FRAME_CLKS);
        check_state("pushpop");
        read_n(4);
        check_state("pushpop_drain");

        // Reset during the data bits of a frame
        send_frame(8'h99, 1, 0, FRAME_CLKS);
        send_frame(8'h7E, 1, 0, 5 * BIT_CLKS);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        rx = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        send_frame(8'h81, 1, 0, FRAME_CLKS);
        check_state("after_reset");
        read_n(1);

        // Randomized traffic with random gaps, reads and error clears
        for (int n = 0; n < 25; n++) begin
            logic [7:0] d;
            bit ok;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, 0, FRAME_CLKS);
            if (!ok) begin
                check("rnd_break_busy", busy, 1);
                rx = 1'b1;
                tick(4);
            end
            check_state("rnd");
            read_n($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) clear_errs();
            tick($urandom_range(0, 3));
        end
        read_n(DEPTH);
        check_state("rnd_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receiver for the board's `UART_RXD` pin, the receive end of the 8N1 link whose transmit side drives `UART_TXD`. It oversamples the line on the system clock, deframes one start bit, 8 data bits (LSB first) and one stop bit, and queues each good byte in a small show-ahead FIFO. The processor side or a program loader reads bytes from that FIFO. Framing and overrun errors are reported on sticky flags.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer-truncated, must be ≥ 4.
- `FIFO_DEPTH`, default 4: number of entries. Must be a power of 2.

- `clock_reg` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, idle high, asynchronous to `clock_reg`.
- `rd_en` in 1: pop the FIFO head. Ignored when `empty`=1.
- `err_clr` in 1: clears `frame_err` and `overrun`.
- `rd_data` out 8: FIFO head. Valid while `empty`=0.
- `empty` out 1: FIFO holds no bytes.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `frame_err` out 1: sticky; set when a stop bit is sampled as 0.
- `overrun` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `busy` out 1: receiver state is not IDLE.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer. Both FFs reset to 1. All decisions use the synchronized value `rxs`.
- **Bit timer:** counter from 0 to `CLKS_PER_BIT`-1. It restarts to 0 on every state change and at every bit sample.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs`=0, go to START with the counter at 0.
  - START: at counter = `CLKS_PER_BIT/2`-1, sample `rxs`. If it is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE; no flag is set.
  - DATA: at each counter = `CLKS_PER_BIT`-1, shift `rxs` into the MSB of an 8-bit shift register (LSB arrives first). After the 8th sample, go to STOP.
  - STOP: at counter = `CLKS_PER_BIT`-1, sample `rxs`.
    - If it is 1 and the FIFO is not full: push the byte, go to IDLE.
    - If it is 1 and the FIFO is full: drop the byte, set `overrun`, go to IDLE. Exception: if `rd_en` pops in that same cycle, the push is accepted instead and `overrun` is not set.
    - If it is 0: discard the byte, set `frame_err`, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering start detection.
- **FIFO:** circular buffer with `log2(FIFO_DEPTH)`-bit read and write pointers that wrap around, plus an occupancy count.
  - `rd_data` is the entry at the read pointer (show-ahead). Storage resets to 0x00.
  - Pop and push in the same cycle: count is unchanged; both pointers advance.
- **Error flags:** if `err_clr` and a flag-setting event occur in the same cycle, setting wins.
- **Reset mid-frame:** the state machine returns to IDLE, the FIFO is emptied, and the partial byte is lost.

## Timing
- **Reset values:** `rd_data`=0x00, `empty`=1, `full`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- **Start detection:** `busy` rises 3 clocks after the falling edge at `rx` (2 synchronizer stages plus the IDLE→START register).
- **Latency:** the stop sample is taken about `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` clocks after start detection. Flags, the FIFO count, `empty` and `full` update on that clock edge and are visible the following cycle.
- **Read:** `rd_en`=1 with `empty`=0 pops on that edge. `rd_data`, `empty` and `full` reflect the new head from the next cycle.
- **Back-to-back frames:** a new start bit immediately after a stop bit is accepted. IDLE is occupied for 1 clock before START.
- **Outputs:** all outputs are registered or decoded from registers; none depends combinationally on `rx`.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD`=1, so `CLKS_PER_BIT`=16.
- **Single byte:** release reset, then send 0xA5 as 8N1. Required: `empty` goes 0, `rd_data`=0xA5, no flags set. One-cycle `rd_en` → `empty`=1 on the next cycle.
- **Glitch:** drive `rx` low for 4 clocks, then high. Required: `busy` pulses and returns to 0, FIFO stays empty, no flags set.
- **Framing error:** send 0x3C with stop bit = 0, and hold `rx` low for 40 more clocks. Required: `frame_err`=1, FIFO empty, `busy` stays 1 until `rx` returns high. A following 0x55 is then received correctly. `err_clr` → `frame_err`=0.
- **Overrun:** send 0x01–0x05 without reading. Required: `full`=1 after the 4th byte, `overrun`=1 after the 5th. Reads return 0x01, 0x02, 0x03, 0x04, then `empty`=1.
- **Push and pop together:** with the FIFO full, assert `rd_en` in the stop-sample cycle of the 5th byte. Required: `overrun`=0, count stays 4, order is preserved.
- **Reset mid-frame:** assert `reset` during DATA of 0x7E. Required: all outputs at reset values immediately. A next full frame 0x81 is received intact.
